// File: rtl/layer_frame_sequencer.sv
// Frame sequencer for one residual layer: gates source pixels into the datapath and counts
// main/skip adder outputs. Define LAYER_SEQ_TIMEOUT_EN to build in the drain watchdog.
module layer_frame_sequencer #(
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44,
    parameter int TIMEOUT    = 1024,
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int COL_W = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Src_Valid,
    input  logic             Main_Valid,
    input  logic             Skip_Valid,
    output logic             Feed_Valid,
    output logic             Add_Valid,
    output logic [ROW_W-1:0] Row,
    output logic [COL_W-1:0] Col,
    output logic             Busy,
    output logic             Frame_Done,
    output logic             Align_Err,
    output logic             Timeout_Err,
    output logic [1:0]       dbg_state
);
    localparam int PIXELS = IMG_WIDHT * IMG_HEIGHT;
    localparam int CNT_W  = $clog2(PIXELS + 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDHT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("layer_frame_sequencer: TIMEOUT must be in 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;

    // Valid-only handshakes: there is no backpressure, so a beat is taken on every cycle its
    // valid is high and the sequencer is in a state that accepts it; otherwise it is dropped.
    assign Busy       = (state == FEED) || (state == DRAIN);
    assign Feed_Valid = Src_Valid && (state == FEED);
    assign Add_Valid  = Main_Valid && Skip_Valid && Busy;
    assign Frame_Done = (state == DONE);
    assign dbg_state  = state;

`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;
`else
    assign Timeout_Err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            Row       <= '0;
            Col       <= '0;
            Align_Err <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
            Timeout_Err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state     <= FEED;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        Row       <= '0;
                        Col       <= '0;
                        Align_Err <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
                        wd_cnt      <= '0;
                        Timeout_Err <= 1'b0;
`endif
                    end
                end
                FEED, DRAIN: begin
                    if (Main_Valid != Skip_Valid) Align_Err <= 1'b1;
                    if (Feed_Valid) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (Col == LAST_COL) begin
                            Col <= '0;
                            Row <= (Row == LAST_ROW) ? '0 : Row + 1'b1;
                        end else begin
                            Col <= Col + 1'b1;
                        end
                    end
                    if (Add_Valid) out_cnt <= out_cnt + 1'b1;
                    // Last output wins over last input so a coincident finish skips DRAIN.
                    if (Add_Valid && out_cnt == LAST_PIX) begin
                        state <= DONE;
                    end else if (Feed_Valid && in_cnt == LAST_PIX) begin
                        state <= DRAIN;
                    end
`ifdef LAYER_SEQ_TIMEOUT_EN
                    // Held at zero through FEED, so it starts clean on entering DRAIN.
                    if (Add_Valid || state != DRAIN) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        Timeout_Err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_frame_sequencer.sv
// Directed bench for layer_frame_sequencer on a 4x4 image with TIMEOUT=8.
module tb_layer_frame_sequencer;
    localparam int W = 4;
    localparam int H = 4;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Start = 1'b0;
    logic Src_Valid = 1'b0;
    logic Main_Valid = 1'b0;
    logic Skip_Valid = 1'b0;
    logic Feed_Valid, Add_Valid, Busy, Frame_Done, Align_Err, Timeout_Err;
    logic [1:0] Row, Col, dbg_state;

    int checks = 0;
    int errors = 0;
    int feeds = 0;
    int adds = 0;
    int dones = 0;
    int k;

    always #5 clk = ~clk;

    layer_frame_sequencer #(
        .IMG_WIDHT (W),
        .IMG_HEIGHT(H),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Src_Valid  (Src_Valid),
        .Main_Valid (Main_Valid),
        .Skip_Valid (Skip_Valid),
        .Feed_Valid (Feed_Valid),
        .Add_Valid  (Add_Valid),
        .Row        (Row),
        .Col        (Col),
        .Busy       (Busy),
        .Frame_Done (Frame_Done),
        .Align_Err  (Align_Err),
        .Timeout_Err(Timeout_Err),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive just after the rising edge, settle, then tally at the falling edge.
    task automatic cyc(input logic s, input logic src, input logic m, input logic sk);
        @(posedge clk);
        #1;
        Start = s;
        Src_Valid = src;
        Main_Valid = m;
        Skip_Valid = sk;
        #4;
        if (Feed_Valid) feeds++;
        if (Add_Valid) adds++;
        if (Frame_Done) dones++;
    endtask

    task automatic clear_tallies();
        feeds = 0;
        adds = 0;
        dones = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_feed"}, Feed_Valid, 0);
        chk({tag, "_add"}, Add_Valid, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_row"}, Row, 0);
        chk({tag, "_col"}, Col, 0);
        chk({tag, "_done"}, Frame_Done, 0);
        chk({tag, "_align"}, Align_Err, 0);
        chk({tag, "_tmo"}, Timeout_Err, 0);
        chk({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    initial begin
        // Reset with every input asserted: nothing may leak through.
        Start = 1'b1; Src_Valid = 1'b1; Main_Valid = 1'b1; Skip_Valid = 1'b1;
        #3;
        chk_all_zero("rst");
        Start = 1'b0; Src_Valid = 1'b0; Main_Valid = 1'b0; Skip_Valid = 1'b0;
        #5;
        rst = 1'b1;

        // Full frame, outputs start after 5 feed cycles.
        clear_tallies();
        cyc(1, 0, 0, 0);
        chk("s1_idle", dbg_state, S_IDLE);
        chk("s1_idle_busy", Busy, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, i >= 5, i >= 5);
            chk("s1_state", dbg_state, S_FEED);
            chk("s1_feed", Feed_Valid, 1);
            chk("s1_row", Row, i / W);
            chk("s1_col", Col, i % W);
            chk("s1_add", Add_Valid, (i >= 5) ? 1 : 0);
        end
        for (int d = 0; d < 5; d++) begin
            cyc(0, 0, 1, 1);
            chk("s1_drain_state", dbg_state, S_DRAIN);
            chk("s1_drain_add", Add_Valid, 1);
            chk("s1_drain_busy", Busy, 1);
        end
        cyc(0, 0, 1, 1);
        chk("s1_done_pulse", Frame_Done, 1);
        chk("s1_done_mask", Add_Valid, 0);
        chk("s1_done_busy", Busy, 0);
        cyc(0, 0, 0, 0);
        chk("s1_back_idle", dbg_state, S_IDLE);
        chk("s1_done_low", Frame_Done, 0);
        chk("s1_feeds", feeds, 16);
        chk("s1_adds", adds, 16);
        chk("s1_dones", dones, 1);
        chk("s1_align", Align_Err, 0);

        // Source valid on alternate cycles, then a misaligned beat in DRAIN.
        clear_tallies();
        cyc(1, 0, 0, 0);
        k = 0;
        for (int i = 0; i < 31; i++) begin
            cyc(0, (i % 2) == 0, 0, 0);
            chk("s2_state", dbg_state, S_FEED);
            chk("s2_feed", Feed_Valid, ((i % 2) == 0) ? 1 : 0);
            chk("s2_row", Row, k / W);
            chk("s2_col", Col, k % W);
            if ((i % 2) == 0) k++;
        end
        cyc(0, 1, 0, 0);
        chk("s2_drain_state", dbg_state, S_DRAIN);
        chk("s2_drain_drop", Feed_Valid, 0);
        chk("s2_wrap_row", Row, 0);
        chk("s2_wrap_col", Col, 0);
        cyc(0, 0, 1, 0);
        chk("s2_mis_add", Add_Valid, 0);
        chk("s2_mis_align_pre", Align_Err, 0);
        for (int j = 0; j < 16; j++) begin
            cyc(0, 0, 1, 1);
            chk("s2_add", Add_Valid, 1);
            chk("s2_align_held", Align_Err, 1);
        end
        cyc(0, 0, 0, 0);
        chk("s2_done_pulse", Frame_Done, 1);
        chk("s2_done_align", Align_Err, 1);
        cyc(0, 0, 0, 0);
        chk("s2_idle_align", Align_Err, 1);
        chk("s2_feeds", feeds, 16);
        chk("s2_dones", dones, 1);

        // Coincident last input/output goes straight to DONE; Start mid-FEED ignored.
        clear_tallies();
        cyc(1, 0, 0, 0);
        chk("s3_align_before_start", Align_Err, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(i == 7, 1, 1, 1);
            chk("s3_state", dbg_state, S_FEED);
            chk("s3_row", Row, i / W);
            chk("s3_col", Col, i % W);
            chk("s3_add", Add_Valid, 1);
            if (i == 0) chk("s3_align_cleared", Align_Err, 0);
        end
        cyc(0, 0, 0, 0);
        chk("s3_direct_done", dbg_state, S_DONE);
        chk("s3_done_pulse", Frame_Done, 1);
        cyc(0, 0, 0, 0);
        chk("s3_idle", dbg_state, S_IDLE);
        chk("s3_adds", adds, 16);
        chk("s3_dones", dones, 1);

        // Outputs stop after 10: watchdog (if built) or indefinite DRAIN.
        clear_tallies();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, i < 10, i < 10);
        end
        chk("s4_adds_feed", adds, 10);
`ifdef LAYER_SEQ_TIMEOUT_EN
        for (int d = 0; d < 8; d++) begin
            cyc(0, 0, 0, 0);
            chk("s4_wd_state", dbg_state, S_DRAIN);
            chk("s4_wd_tmo_low", Timeout_Err, 0);
        end
        cyc(0, 0, 0, 0);
        chk("s4_wd_idle", dbg_state, S_IDLE);
        chk("s4_wd_tmo", Timeout_Err, 1);
        chk("s4_wd_busy", Busy, 0);
        for (int d = 0; d < 3; d++) cyc(0, 0, 0, 0);
        chk("s4_wd_tmo_held", Timeout_Err, 1);
        chk("s4_wd_dones", dones, 0);
`else
        for (int d = 0; d < 20; d++) begin
            cyc(0, 0, 0, 0);
            chk("s4_hold_state", dbg_state, S_DRAIN);
            chk("s4_hold_tmo", Timeout_Err, 0);
        end
        cyc(1, 0, 1, 1);
        chk("s4_start_in_drain", dbg_state, S_DRAIN);
        chk("s4_start_add", Add_Valid, 1);
        for (int d = 0; d < 5; d++) begin
            cyc(0, 0, 1, 1);
            chk("s4_add", Add_Valid, 1);
        end
        cyc(0, 0, 1, 1);
        chk("s4_done_pulse", Frame_Done, 1);
        chk("s4_done_mask", Add_Valid, 0);
        cyc(0, 0, 0, 0);
        chk("s4_idle", dbg_state, S_IDLE);
        chk("s4_adds", adds, 16);
        chk("s4_dones", dones, 1);
`endif

        // Reset after 7 pixels, then a clean frame.
        clear_tallies();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 1);
        @(posedge clk);
        #1;
        Start = 1'b1; Src_Valid = 1'b1; Main_Valid = 1'b1; Skip_Valid = 1'b1;
        #2;
        chk("s5_pre_rst_feed", Feed_Valid, 1);
        chk("s5_pre_rst_row", Row, 1);
        chk("s5_pre_rst_col", Col, 3);
        rst = 1'b0;
        #1;
        chk_all_zero("s5_rst");
        @(posedge clk);
        #3;
        chk("s5_rst_hold", dbg_state, S_IDLE);
        chk("s5_rst_nodone", dones, 0);
        Start = 1'b0; Src_Valid = 1'b0; Main_Valid = 1'b0; Skip_Valid = 1'b0;
        rst = 1'b1;
        clear_tallies();
        cyc(0, 1, 1, 1);
        chk("s5_idle_drop", Feed_Valid, 0);
        chk("s5_idle_add", Add_Valid, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 1);
            chk("s5_row", Row, i / W);
            chk("s5_col", Col, i % W);
            if (i == 0) chk("s5_tmo_cleared", Timeout_Err, 0);
        end
        cyc(0, 0, 0, 0);
        chk("s5_done_pulse", Frame_Done, 1);
        cyc(0, 0, 0, 0);
        chk("s5_idle", dbg_state, S_IDLE);
        chk("s5_feeds", feeds, 16);
        chk("s5_adds", adds, 16);
        chk("s5_dones", dones, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
